mem_ctrl: RTL

LC-3 memory controller, the block behind the CPU's memory interface (Patt microarchitecture, Appendix C). It owns MAR and MDR, sequences multi-cycle SRAM accesses and generates the R (ready) signal the control store waits on. It decodes the memory-mapped device registers (KBSR, KBDR, DSR, DDR, MCR) and exposes device-side handshakes and interrupt requests.

---
 rtl/mem_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- LC-3 memory controller.
//
// Owns MAR and MDR, sequences MEM_LAT-cycle SRAM accesses and produces the R
// (mem_rdy) signal the control store waits on. With LC3_MMIO_EN defined it also
// decodes the memory-mapped device registers (KBSR xFE00, KBDR xFE02,
// DSR xFE04, DDR xFE06, MCR xFFFE) and drives the keyboard/display handshakes
// and interrupt requests. Without LC3_MMIO_EN every address is SRAM and the
// device outputs are tied to their idle values (run=1).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus             16-bit system bus; MDR driven onto it when mem_gate_mdr=1
//   mem_ld_mar      MAR <- bus
//   mem_ld_mdr      MDR <- bus (mio_en=0) or read data (mio_en=1, rdy, read)
//   mem_mio_en      access enable; mem_rw 1=write 0=read
//   mem_gate_mdr    drive MDR onto bus
//   mem_rdy         R: access completes at this edge
//   sram_*          SRAM port: addr=MAR, wdata=MDR, async rdata, 1-cycle we
//   kb_valid/kb_data        keyboard character strobe
//   dsp_ready/dsp_valid/dsp_data  display handshake
//   kb_irq, dsp_irq, run    interrupt requests and CPU clock enable (MCR[15])
// -----------------------------------------------------------------------------
module mem_ctrl #(
   parameter int MEM_LAT = 5
) (
   input  logic        clk,
   input  logic        rst,
   inout  wire  [15:0] bus,
   input  logic        mem_ld_mar,
   input  logic        mem_ld_mdr,
   input  logic        mem_mio_en,
   input  logic        mem_rw,
   input  logic        mem_gate_mdr,
   output logic        mem_rdy,
   output logic [15:0] sram_addr,
   output logic [15:0] sram_wdata,
   input  logic [15:0] sram_rdata,
   output logic        sram_we,
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   input  logic        dsp_ready,
   output logic        dsp_valid,
   output logic [7:0]  dsp_data,
   output logic        kb_irq,
   output logic        dsp_irq,
   output logic        run
);

   localparam int CW = $clog2(MEM_LAT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

   logic [15:0]   r_mar;
   logic [15:0]   r_mdr;
   logic [CW-1:0] r_cnt;

   logic          w_io_hit;
   logic [15:0]   w_io_rdata;
   logic [15:0]   w_rdata;
   logic          w_rdy;
   logic          w_rd_done;
   logic          w_wr_done;

   // Device registers answer in the first cycle; SRAM after MEM_LAT cycles.
   assign w_rdy     = mem_mio_en & (w_io_hit | (r_cnt == CNT_LAST));
   assign w_rd_done = w_rdy & ~mem_rw;
   assign w_wr_done = w_rdy &  mem_rw;

   assign mem_rdy    = w_rdy;
   assign sram_addr  = r_mar;
   assign sram_wdata = r_mdr;
   assign sram_we    = w_wr_done & ~w_io_hit;
   assign bus        = mem_gate_mdr ? r_mdr : 16'hzzzz;
   assign w_rdata    = w_io_hit ? w_io_rdata : sram_rdata;

   // Cycle counter: restarts after every completion and whenever the access
   // is dropped, so an aborted access runs the full latency when re-raised.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_cnt <= '0;
      else if (!mem_mio_en || w_rdy) r_cnt <= '0;
      else                          r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             r_mar <= '0;
      else if (mem_ld_mar) r_mar <= bus;
   end

   // With mio_en high, MDR only changes on the completing read edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            r_mdr <= '0;
      else if (mem_ld_mdr && !mem_mio_en) r_mdr <= bus;
      else if (mem_ld_mdr && w_rd_done)   r_mdr <= w_rdata;
   end

`ifdef LC3_MMIO_EN
   localparam logic [15:0] A_KBSR = 16'hFE00;
   localparam logic [15:0] A_KBDR = 16'hFE02;
   localparam logic [15:0] A_DSR  = 16'hFE04;
   localparam logic [15:0] A_DDR  = 16'hFE06;
   localparam logic [15:0] A_MCR  = 16'hFFFE;

   logic       r_kb_rdy, r_kb_ie, r_ds_rdy, r_ds_ie, r_mcr, r_dsp_valid;
   logic [7:0] r_kbdr, r_dsp_data;
   logic       w_sel_kbsr, w_sel_kbdr, w_sel_dsr, w_sel_ddr, w_sel_mcr;

   assign w_sel_kbsr = (r_mar == A_KBSR);
   assign w_sel_kbdr = (r_mar == A_KBDR);
   assign w_sel_dsr  = (r_mar == A_DSR);
   assign w_sel_ddr  = (r_mar == A_DDR);
   assign w_sel_mcr  = (r_mar == A_MCR);
   assign w_io_hit   = w_sel_kbsr | w_sel_kbdr | w_sel_dsr | w_sel_ddr | w_sel_mcr;

   always_comb begin
      w_io_rdata = '0;
      if (w_sel_kbsr) w_io_rdata = {r_kb_rdy, r_kb_ie, 14'b0};
      if (w_sel_kbdr) w_io_rdata = {8'b0, r_kbdr};
      if (w_sel_dsr)  w_io_rdata = {r_ds_rdy, r_ds_ie, 14'b0};
      if (w_sel_ddr)  w_io_rdata = {8'b0, r_dsp_data};
      if (w_sel_mcr)  w_io_rdata = {r_mcr, 15'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_kb_rdy    <= 1'b0;
         r_kb_ie     <= 1'b0;
         r_kbdr      <= '0;
         r_ds_rdy    <= 1'b1;
         r_ds_ie     <= 1'b0;
         r_mcr       <= 1'b1;
         r_dsp_valid <= 1'b0;
         r_dsp_data  <= '0;
      end else begin
         r_dsp_valid <= w_wr_done & w_sel_ddr;
         // A new character beats a simultaneous KBDR read.
         if (kb_valid) begin
            r_kb_rdy <= 1'b1;
            r_kbdr   <= kb_data;
         end else if (w_rd_done && w_sel_kbdr) begin
            r_kb_rdy <= 1'b0;
         end
         if (w_wr_done && w_sel_kbsr) r_kb_ie <= r_mdr[14];
         if (w_wr_done && w_sel_dsr)  r_ds_ie <= r_mdr[14];
         if (w_wr_done && w_sel_mcr)  r_mcr   <= r_mdr[15];
         // Display ready is only re-armed once the dsp_valid pulse has gone.
         if (w_wr_done && w_sel_ddr) begin
            r_ds_rdy   <= 1'b0;
            r_dsp_data <= r_mdr[7:0];
         end else if (dsp_ready && !r_dsp_valid) begin
            r_ds_rdy <= 1'b1;
         end
      end
   end

   assign dsp_valid = r_dsp_valid;
   assign dsp_data  = r_dsp_data;
   assign kb_irq    = r_kb_rdy & r_kb_ie;
   assign dsp_irq   = r_ds_rdy & r_ds_ie;
   assign run       = r_mcr;
`else
   logic w_unused_dev;

   assign w_io_hit     = 1'b0;
   assign w_io_rdata   = '0;
   assign dsp_valid    = 1'b0;
   assign dsp_data     = '0;
   assign kb_irq       = 1'b0;
   assign dsp_irq      = 1'b0;
   assign run          = 1'b1;
   assign w_unused_dev = ^{kb_valid, kb_data, dsp_ready};
`endif

endmodule
